// File: rtl/multi_channel_network_controller_if.sv
// Spike input channels and spike output handshake between the controller and its neighbours.
interface multi_channel_network_controller_if #(
  parameter int NUM_CH   = 4,
  parameter int SR_DEPTH = 16384,
  parameter int NR_DEPTH = 16
);
  logic [NUM_CH-1:0]                   in_valid;
  logic [NUM_CH*$clog2(SR_DEPTH)-1:0]  in_index;
  logic [NUM_CH-1:0]                   in_ready;
  logic                                out_valid;
  logic [$clog2(NR_DEPTH)-1:0]         out_index;
  logic                                out_ready;
  logic                                out_drop;

  modport master (
    output in_valid, in_index, out_ready,
    input  in_ready, out_valid, out_index, out_drop
  );

  modport slave (
    input  in_valid, in_index, out_ready,
    output in_ready, out_valid, out_index, out_drop
  );
endinterface

// File: rtl/multi_channel_network_controller.sv
// Sequences two-phase neuron updates and per-input synapse sweeps over time steps.
// Inputs are round-robin queued from NUM_CH channels; fired spikes are exposed on a one-deep output.
module multi_channel_network_controller #(
  parameter int NR_DEPTH         = 16,
  parameter int SR_DEPTH         = 16384,
  parameter int NUM_CH           = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int MAX_NETWORK_TIME = 65536
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  spike_fired,
  multi_channel_network_controller_if.slave     bus,
  output logic [$clog2(NR_DEPTH)-1:0]           c_neuron_index,
  output logic [$clog2(SR_DEPTH)-1:0]           c_synapse_index,
  output logic                                  c_neuron_we,
  output logic                                  c_input,
  output logic [$clog2(MAX_NETWORK_TIME):0]     network_time,
  output logic                                  step_done,
  output logic                                  busy
);
  localparam int NW = $clog2(NR_DEPTH);
  localparam int SW = $clog2(SR_DEPTH);
  localparam int TW = $clog2(MAX_NETWORK_TIME) + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PROC_NEURON = 2'd1;
  localparam logic [1:0] PROC_INPUT  = 2'd2;

  localparam logic [NW-1:0] LAST_N = NW'(NR_DEPTH - 1);
  localparam logic [TW-1:0] MAX_T  = TW'(MAX_NETWORK_TIME);

  logic [1:0]    state;
  logic          phase;
  logic [NW-1:0] i_upd;
  logic [NW-1:0] i_inp;

  logic [SW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [KW-1:0] count;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] gnt;
  logic          gnt_vld;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          step_wrap;
  logic          run_end;
  logic          spike_new;
  logic          out_accept;
  logic [TW-1:0] time_inc;
  logic [SW-1:0] push_dat;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == KW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign step_wrap  = (state == PROC_NEURON) && phase && (i_upd == LAST_N);
  assign time_inc   = network_time + 1'b1;
  assign run_end    = step_wrap && (time_inc == MAX_T);
  // The final step of a run leaves the queue untouched for the next run.
  assign pop        = !empty && phase &&
                      (((state == PROC_NEURON) && !run_end) ||
                       ((state == PROC_INPUT) && (i_inp == LAST_N)));
  assign spike_new  = (state == PROC_NEURON) && phase && spike_fired;
  assign out_accept = bus.out_valid && bus.out_ready;
  assign busy       = (state != IDLE);

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int o = NUM_CH - 1; o >= 0; o--) begin
      if (bus.in_valid[(int'(rr_ptr) + o) % NUM_CH]) begin
        gnt     = CW'((int'(rr_ptr) + o) % NUM_CH);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (gnt_vld && !full) bus.in_ready[gnt] = 1'b1;
  end

  assign push     = gnt_vld && !full;
  assign push_dat = bus.in_index[int'(gnt)*SW +: SW];

  always_comb begin
    c_neuron_index = '0;
    c_neuron_we    = 1'b0;
    c_input        = 1'b0;
    case (state)
      PROC_NEURON: begin
        c_neuron_index = i_upd;
        c_neuron_we    = phase;
      end
      PROC_INPUT: begin
        c_neuron_index = i_inp;
        c_neuron_we    = phase;
        c_input        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
        rr_ptr <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + KW'(push) - KW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      phase           <= 1'b0;
      i_upd           <= '0;
      i_inp           <= '0;
      network_time    <= '0;
      c_synapse_index <= '0;
      step_done       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (pop) c_synapse_index <= mem[rd_ptr];
      case (state)
        IDLE: begin
          if (start) begin
            network_time <= '0;
            i_upd        <= '0;
            phase        <= 1'b0;
            state        <= PROC_NEURON;
          end
        end
        PROC_NEURON: begin
          phase <= !phase;
          if (phase) begin
            if (step_wrap) begin
              i_upd        <= '0;
              network_time <= time_inc;
              step_done    <= 1'b1;
              if (run_end) state <= IDLE;
            end else begin
              i_upd <= i_upd + 1'b1;
            end
            if (pop) begin
              i_inp <= '0;
              state <= PROC_INPUT;
            end
          end
        end
        PROC_INPUT: begin
          phase <= !phase;
          if (phase) begin
            if (i_inp == LAST_N) begin
              i_inp <= '0;
              if (!pop) state <= PROC_NEURON;
            end else begin
              i_inp <= i_inp + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pending unaccepted spike wins over a newer one; the loss is recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      bus.out_drop  <= 1'b0;
    end else if (spike_new) begin
      if (!bus.out_valid || out_accept) begin
        bus.out_valid <= 1'b1;
        bus.out_index <= i_upd;
      end else begin
        bus.out_drop <= 1'b1;
      end
    end else if (out_accept) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_channel_network_controller.sv
// Randomized and directed bench against a queue-based reference of the controller rules.
module tb_multi_channel_network_controller;
  localparam int NR   = 4;
  localparam int SR   = 64;
  localparam int NCH  = 2;
  localparam int FD   = 2;
  localparam int MAXT = 2;
  localparam int SW   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       spike_fired = 1'b0;
  logic [1:0] c_neuron_index;
  logic [5:0] c_synapse_index;
  logic       c_neuron_we;
  logic       c_input;
  logic [1:0] network_time;
  logic       step_done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  multi_channel_network_controller_if #(.NUM_CH(NCH), .SR_DEPTH(SR), .NR_DEPTH(NR)) bus ();

  multi_channel_network_controller #(
    .NR_DEPTH(NR), .SR_DEPTH(SR), .NUM_CH(NCH), .FIFO_DEPTH(FD), .MAX_NETWORK_TIME(MAXT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .spike_fired     (spike_fired),
    .bus             (bus.slave),
    .c_neuron_index  (c_neuron_index),
    .c_synapse_index (c_synapse_index),
    .c_neuron_we     (c_neuron_we),
    .c_input         (c_input),
    .network_time    (network_time),
    .step_done       (step_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference: a run is a sweep position 0..2*NR-1 (neuron = pos/2, write = pos odd),
  // optionally suspended by an input sweep position; queued inputs live in a queue.
  bit m_run, m_sweep;
  int m_upos, m_ipos, m_time, m_sidx, m_sd, m_rr, m_ov, m_oi, m_drop;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_ready();
    int r;
    r = 0;
    if (q.size() < FD) begin
      for (int o = 0; o < NCH; o++) begin
        if (bus.in_valid[(m_rr + o) % NCH]) begin
          r = 1 << ((m_rr + o) % NCH);
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    int g, nidx;
    bit was_w, stop, spk, acc;
    if (reset) begin
      m_run = 0; m_sweep = 0; m_upos = 0; m_ipos = 0; m_time = 0; m_sidx = 0;
      m_sd = 0; m_rr = 0; m_ov = 0; m_oi = 0; m_drop = 0;
      q.delete();
      return;
    end
    g = -1;
    if (q.size() < FD) begin
      for (int o = 0; o < NCH; o++) begin
        if (g < 0 && bus.in_valid[(m_rr + o) % NCH]) g = (m_rr + o) % NCH;
      end
    end
    m_sd = 0; spk = 0; stop = 0; nidx = 0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_sweep = 0; m_upos = 0; m_time = 0;
      end
    end else if (!m_sweep) begin
      was_w = (m_upos % 2) == 1;
      nidx  = m_upos / 2;
      spk   = was_w && spike_fired;
      m_upos = (m_upos + 1) % (2 * NR);
      if (was_w && m_upos == 0) begin
        m_time++;
        m_sd = 1;
        if (m_time == MAXT) begin stop = 1; m_run = 0; end
      end
      if (was_w && !stop && q.size() > 0) begin
        m_sidx = q.pop_front(); m_ipos = 0; m_sweep = 1;
      end
    end else begin
      was_w = (m_ipos % 2) == 1;
      m_ipos = (m_ipos + 1) % (2 * NR);
      if (was_w && m_ipos == 0) begin
        if (q.size() > 0) m_sidx = q.pop_front();
        else m_sweep = 0;
      end
    end
    acc = (m_ov != 0) && bus.out_ready;
    if (spk) begin
      if (m_ov == 0 || acc) begin m_ov = 1; m_oi = nidx; end
      else m_drop = 1;
    end else if (acc) begin
      m_ov = 0;
    end
    if (g >= 0) begin
      q.push_back(int'(bus.in_index[g*SW +: SW]));
      m_rr = (g + 1) % NCH;
    end
  endtask

  task automatic check_all();
    #1;
    chk("in_ready", bus.in_ready, exp_ready());
    chk("c_neuron_index", c_neuron_index, !m_run ? 0 : (m_sweep ? m_ipos / 2 : m_upos / 2));
    chk("c_neuron_we", c_neuron_we, !m_run ? 0 : (m_sweep ? m_ipos % 2 : m_upos % 2));
    chk("c_input", c_input, m_run && m_sweep);
    chk("c_synapse_index", c_synapse_index, m_sidx);
    chk("network_time", network_time, m_time);
    chk("step_done", step_done, m_sd);
    chk("busy", busy, m_run);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_index", bus.out_index, m_oi);
    chk("out_drop", bus.out_drop, m_drop);
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200 && busy; n++) tick();
    chk(tag, busy, 0);
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_index  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Empty-queue run: two steps then idle.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("seq_index", c_neuron_index, k / 2);
      chk("seq_we", c_neuron_we, k % 2);
      tick();
    end
    #1;
    chk("step1_done", step_done, 1);
    chk("step1_time", network_time, 1);
    chk("step1_busy", busy, 1);
    repeat (8) tick();
    #1;
    chk("run_end_busy", busy, 0);
    chk("run_end_time", network_time, 2);

    // Arbitration, full queue backpressure and input sweeps.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.in_valid = 2'b11;
    bus.in_index = {6'd9, 6'd5};
    #1 chk("arb_ch0", bus.in_ready, 1);
    tick();
    #1 chk("arb_ch1", bus.in_ready, 2);
    tick();
    bus.in_valid = 2'b01;
    bus.in_index = {6'd0, 6'd7};
    #1 chk("full_idle", bus.in_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    #1 chk("full_ph0", bus.in_ready, 0);
    tick();
    #1 chk("full_pop_cycle", bus.in_ready, 0);
    tick();
    #1;
    chk("pop_first", c_synapse_index, 5);
    chk("sweep_c_input", c_input, 1);
    chk("push_after_pop", bus.in_ready, 1);
    tick();
    bus.in_valid = '0;
    repeat (7) tick();
    #1 chk("pop_second", c_synapse_index, 9);
    repeat (8) tick();
    #1 chk("pop_third", c_synapse_index, 7);
    repeat (8) tick();
    #1;
    chk("resume_c_input", c_input, 0);
    chk("resume_neuron", c_neuron_index, 1);
    wait_idle("sweep_run_idle");

    // Spike output hold, drop and acceptance, then reset mid-run.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      spike_fired = (k == 5 || k == 7);
      tick();
    end
    spike_fired = 1'b0;
    #1;
    chk("spike_valid", bus.out_valid, 1);
    chk("spike_index", bus.out_index, 2);
    chk("spike_drop", bus.out_drop, 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    #1 chk("spike_accepted", bus.out_valid, 0);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_drop", bus.out_drop, 0);
    chk("rst_time", network_time, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = 2'($urandom_range(0, 3));
      bus.in_index  = 12'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      spike_fired   = 1'($urandom_range(0, 1));
      start         = ($urandom_range(0, 7) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; bus.in_valid = '0;
    wait_idle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
